// File: rtl/fetch_unit.sv
// Qu core instruction fetch front end: sequential PC generation, in-order imem requests,
// response FIFO toward decode, redirect flush. Optional stall counter via QU_FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_out,
`ifdef QU_FETCH_STALL_CNT_EN
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic [31:0]            stall_cnt
`else
  output logic [ADDR_WIDTH-1:0]  pc_out
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DEPTH_INT = FIFO_DEPTH;
  localparam logic [CW:0] DEPTH_L = DEPTH_INT[CW:0];

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [CW-1:0]          out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0]          frd_q, frd_d, fwr_q, fwr_d, qrd_q, qrd_d, qwr_q, qwr_d;
  logic [INSTR_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  pcq_q        [FIFO_DEPTH];
  logic [CW:0]            inflight;
  logic                   req_fire, push, pop;

  // Credits cover both in-flight requests and buffered words, so a response always has a slot.
  assign inflight       = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !rst && !redirect && (inflight < DEPTH_L);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign instr_valid    = (cnt_q != '0);
  assign pop            = instr_valid && instr_ready && !redirect;
  assign push           = imem_rsp_valid && (drop_q == '0) && !redirect;
  assign instr_out      = instr_valid ? fifo_instr_q[frd_q] : '0;
  assign pc_out         = instr_valid ? fifo_pc_q[frd_q] : '0;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    frd_d  = frd_q;
    fwr_d  = fwr_q;
    qrd_d  = qrd_q;
    qwr_d  = qwr_q;
    if (imem_rsp_valid) begin
      qrd_d = qrd_q + PW'(1);
    end
    if (redirect) begin
      pc_d   = redirect_pc;
      cnt_d  = '0;
      frd_d  = '0;
      fwr_d  = '0;
      out_d  = out_q - CW'(imem_rsp_valid);
      drop_d = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d  = pc_q + ADDR_WIDTH'(4);
        qwr_d = qwr_q + PW'(1);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        fwr_d = fwr_q + PW'(1);
      end
      if (pop) begin
        frd_d = frd_q + PW'(1);
      end
      out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      frd_q  <= '0;
      fwr_q  <= '0;
      qrd_q  <= '0;
      qwr_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      frd_q  <= frd_d;
      fwr_q  <= fwr_d;
      qrd_q  <= qrd_d;
      qwr_q  <= qwr_d;
    end
  end

  // Storage needs no reset: occupancy counters alone decide what is visible.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_q[qwr_q] <= pc_q;
    end
    if (push) begin
      fifo_instr_q[fwr_q] <= imem_rsp_data;
      fifo_pc_q[fwr_q]    <= pcq_q[qrd_q];
    end
  end

`ifdef QU_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (instr_ready && !instr_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
